// File: rtl/sdram_client_arbiter.sv
// Purpose: arbitrates two word-at-a-time SDRAM clients (A = display, priority; B = fractal, yields) onto one controller port.
// Latency: one word outstanding; write word 4 cycles minimum, read word 4 cycles plus controller read latency.
// Backpressure: o_Mem_Req is held with stable addr/data until i_Mem_Ack; clients hold their command until their done/valid pulse.
// Build option: define SDRAM_ARB_WATCHDOG_EN to include the sticky yield-timeout watchdog.
module sdram_client_arbiter #(
    parameter int ADDR_W        = 22,
    parameter int DATA_W        = 32,
    parameter int YIELD_TIMEOUT = 1024
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [1:0]        i_A_Command,
    input  logic [ADDR_W-1:0] i_A_Address,
    input  logic [DATA_W-1:0] i_A_Write,
    output logic              o_A_Read_Valid,
    output logic              o_A_Write_Done,
    input  logic [1:0]        i_B_Command,
    input  logic [ADDR_W-1:0] i_B_Address,
    input  logic [DATA_W-1:0] i_B_Write,
    output logic              o_B_Read_Valid,
    output logic              o_B_Write_Done,
    output logic              o_B_Requested,
    input  logic              i_B_Yield,
    output logic [DATA_W-1:0] o_Read_Data,
    output logic              o_Mem_Req,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic              i_Mem_Ack,
    input  logic              i_Mem_Rvalid,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    output logic              o_Yield_Timeout
);
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [1:0] {OWN_B, WAIT_YIELD, OWN_A} arb_t;
    typedef enum logic [2:0] {W_IDLE, W_REQ, W_RD, W_DONE, W_SETTLE} word_t;

    arb_t              r_arb, w_arb_nxt;
    word_t             r_word, w_word_nxt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_a_active, w_own_a, w_own_b, w_start, w_capture;
    logic [1:0]        w_sel_cmd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_a_active = (i_A_Command == CMD_READ) || (i_A_Command == CMD_WRITE);
    assign w_own_a    = (r_arb == OWN_A);
    assign w_own_b    = (r_arb == OWN_B);

    // Command the word engine may act on: A when it owns memory; B only while it owns memory and A is not asking
    always_comb begin
        w_sel_cmd  = 2'd0;
        w_sel_addr = i_B_Address;
        w_sel_data = i_B_Write;
        if (w_own_a) begin
            w_sel_cmd  = i_A_Command;
            w_sel_addr = i_A_Address;
            w_sel_data = i_A_Write;
        end else if (w_own_b && !w_a_active) begin
            w_sel_cmd  = i_B_Command;
        end
    end

    assign w_start   = (r_word == W_IDLE) && ((w_sel_cmd == CMD_READ) || (w_sel_cmd == CMD_WRITE));
    assign w_capture = ((r_word == W_REQ) && i_Mem_Ack && !r_mem_we && i_Mem_Rvalid) ||
                       ((r_word == W_RD) && i_Mem_Rvalid);

    // State registers for the ownership and word FSMs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_arb  <= OWN_B;
            r_word <= W_IDLE;
        end else begin
            r_arb  <= w_arb_nxt;
            r_word <= w_word_nxt;
        end
    end

    // Ownership: hand memory to A only after B yields, and only between words
    always_comb begin
        w_arb_nxt = r_arb;
        case (r_arb)
            OWN_B:      if (w_a_active && (r_word == W_IDLE)) w_arb_nxt = WAIT_YIELD;
            WAIT_YIELD: if (i_B_Yield) w_arb_nxt = OWN_A;
            OWN_A:      if (!w_a_active && (r_word == W_IDLE)) w_arb_nxt = OWN_B;
            default:    w_arb_nxt = OWN_B;
        endcase
    end

    // Word sequencing: request, optional read wait, one-cycle pulse, one dead cycle for the client to advance
    always_comb begin
        w_word_nxt = r_word;
        case (r_word)
            W_IDLE:   if (w_start) w_word_nxt = W_REQ;
            W_REQ:    if (i_Mem_Ack) w_word_nxt = (r_mem_we || i_Mem_Rvalid) ? W_DONE : W_RD;
            W_RD:     if (i_Mem_Rvalid) w_word_nxt = W_DONE;
            W_DONE:   w_word_nxt = W_SETTLE;
            W_SETTLE: w_word_nxt = W_IDLE;
            default:  w_word_nxt = W_IDLE;
        endcase
    end

    // Latch the owner's request at word start and keep the most recent read word
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_start) begin
                r_mem_we    <= (w_sel_cmd == CMD_WRITE);
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_data;
            end
            if (w_capture) r_rdata <= i_Mem_Rdata;
        end
    end

    assign o_Mem_Req      = (r_word == W_REQ);
    assign o_Mem_We       = r_mem_we;
    assign o_Mem_Addr     = r_mem_addr;
    assign o_Mem_Wdata    = r_mem_wdata;
    assign o_Read_Data    = r_rdata;
    assign o_B_Requested  = !w_own_b;
    // No word ever runs during WAIT_YIELD, so the owner is stable for the whole word
    assign o_A_Read_Valid = (r_word == W_DONE) && w_own_a && !r_mem_we;
    assign o_A_Write_Done = (r_word == W_DONE) && w_own_a && r_mem_we;
    assign o_B_Read_Valid = (r_word == W_DONE) && w_own_b && !r_mem_we;
    assign o_B_Write_Done = (r_word == W_DONE) && w_own_b && r_mem_we;

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int               CNT_W   = $clog2(YIELD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(YIELD_TIMEOUT - 1);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout;

    // Count cycles spent waiting for B to yield; the flag stays set until reset and does not affect arbitration
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (r_arb != WAIT_YIELD) begin
            r_wd_cnt  <= '0;
        end else if (r_wd_cnt != WD_LAST) begin
            r_wd_cnt  <= r_wd_cnt + 1'b1;
        end else begin
            r_timeout <= 1'b1;
        end
    end
    assign o_Yield_Timeout = r_timeout;
`else
    // Without the watchdog the timeout parameter has no effect
    logic w_unused_cfg;
    assign w_unused_cfg    = ^YIELD_TIMEOUT;
    assign o_Yield_Timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_client_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_client_arbiter;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int YT     = 16;
    localparam int TMO    = 400;
    localparam logic [ADDR_W-1:0] B_BASE = 22'h20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        i_A_Command = 2'd0, i_B_Command = 2'd0;
    logic [ADDR_W-1:0] i_A_Address = '0, i_B_Address = '0;
    logic [DATA_W-1:0] i_A_Write = '0, i_B_Write = '0;
    logic              i_B_Yield = 1'b0;
    logic              i_Mem_Ack = 1'b0, i_Mem_Rvalid = 1'b0;
    logic [DATA_W-1:0] i_Mem_Rdata = '0;
    logic              o_A_Read_Valid, o_A_Write_Done, o_B_Read_Valid, o_B_Write_Done;
    logic              o_B_Requested, o_Mem_Req, o_Mem_We, o_Yield_Timeout;
    logic [DATA_W-1:0] o_Read_Data, o_Mem_Wdata;
    logic [ADDR_W-1:0] o_Mem_Addr;

    sdram_client_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .YIELD_TIMEOUT(YT)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_A_Command(i_A_Command), .i_A_Address(i_A_Address), .i_A_Write(i_A_Write),
        .o_A_Read_Valid(o_A_Read_Valid), .o_A_Write_Done(o_A_Write_Done),
        .i_B_Command(i_B_Command), .i_B_Address(i_B_Address), .i_B_Write(i_B_Write),
        .o_B_Read_Valid(o_B_Read_Valid), .o_B_Write_Done(o_B_Write_Done),
        .o_B_Requested(o_B_Requested), .i_B_Yield(i_B_Yield), .o_Read_Data(o_Read_Data),
        .o_Mem_Req(o_Mem_Req), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr), .o_Mem_Wdata(o_Mem_Wdata),
        .i_Mem_Ack(i_Mem_Ack), .i_Mem_Rvalid(i_Mem_Rvalid), .i_Mem_Rdata(i_Mem_Rdata),
        .o_Yield_Timeout(o_Yield_Timeout)
    );

    typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } op_t;

    op_t exp_mem_a[$], exp_mem_b[$], exp_pls_a[$], exp_pls_b[$];
    logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ctrl_mem [logic [ADDR_W-1:0]];

    int n_cmp = 0, n_bad = 0;
    int pulses_a = 0, pulses_b = 0;
    int ack_lo = 0, ack_hi = 2, rv_lo = 0, rv_hi = 3;
    logic b_active = 1'b0;
    logic yielded;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: an unwritten word reads back as its own address
    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return DATA_W'(a);
    endfunction

    function automatic logic pick_we(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic issue_word(input logic is_a, input logic we, input logic [ADDR_W-1:0] addr, output op_t op);
        op.we   = we;
        op.addr = addr;
        if (we) begin
            op.data = $urandom;
            ref_mem[addr] = op.data;
        end else begin
            op.data = ref_read(addr);
        end
        if (is_a) begin exp_mem_a.push_back(op); exp_pls_a.push_back(op); end
        else begin exp_mem_b.push_back(op); exp_pls_b.push_back(op); end
    endtask

    task automatic a_burst(input int n, input int mode, input logic [ADDR_W-1:0] base);
        op_t op;
        int t;
        for (int i = 0; i < n; i++) begin
            issue_word(1'b1, pick_we(mode), base + ADDR_W'(i), op);
            i_A_Command = op.we ? 2'd2 : 2'd1;
            i_A_Address = op.addr;
            i_A_Write   = op.we ? op.data : $urandom;
            t = 0;
            do begin @(negedge clk); t++; end
            while (!(o_A_Read_Valid || o_A_Write_Done) && t < TMO);
            check("a_word_served", t < TMO, 1'b1);
        end
        i_A_Command = 2'd0;
    endtask

    // B finishes its current word, then on o_B_Requested holds off briefly, drops its command and yields
    task automatic b_burst(input int n, input int mode, input logic [ADDR_W-1:0] base);
        op_t op;
        int t;
        logic [1:0] cmd;
        b_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            issue_word(1'b0, pick_we(mode), base + ADDR_W'(i), op);
            cmd = op.we ? 2'd2 : 2'd1;
            i_B_Command = cmd;
            i_B_Address = op.addr;
            i_B_Write   = op.we ? op.data : $urandom;
            t = 0;
            while (t < TMO) begin
                @(negedge clk); t++;
                if (o_B_Read_Valid || o_B_Write_Done) break;
                if (o_B_Requested) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    i_B_Command = 2'd0;
                    i_B_Yield   = 1'b1;
                    while (o_B_Requested && t < TMO) begin @(negedge clk); t++; end
                    i_B_Yield   = 1'b0;
                    i_B_Command = cmd;
                end
            end
            check("b_word_served", t < TMO, 1'b1);
        end
        i_B_Command = 2'd0;
        b_active = 1'b0;
    endtask

    // An idle B releases memory as soon as it is asked
    initial forever begin
        @(negedge clk);
        if (!b_active) i_B_Yield = o_B_Requested;
    end

    // Tracks whether B has actually yielded during the current request episode
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              yielded <= 1'b0;
        else if (!o_B_Requested) yielded <= 1'b0;
        else if (i_B_Yield)      yielded <= 1'b1;
    end

    // Controller model plus request-side checks (ordering, fields, stability)
    initial begin : ctrl
        int wait_c, rv_c, dly;
        logic in_req, rv_pend;
        logic [DATA_W-1:0] rv_data;
        logic [ADDR_W-1:0] s_addr;
        logic [DATA_W-1:0] s_wdata;
        logic s_we;
        op_t e;
        in_req = 1'b0; rv_pend = 1'b0; wait_c = 0; rv_c = 0;
        forever begin
            @(negedge clk);
            i_Mem_Ack    = 1'b0;
            i_Mem_Rvalid = 1'b0;
            i_Mem_Rdata  = $urandom;
            if (!rst_n) begin
                in_req = 1'b0; rv_pend = 1'b0;
            end else if (rv_pend) begin
                if (rv_c == 0) begin
                    i_Mem_Rvalid = 1'b1; i_Mem_Rdata = rv_data; rv_pend = 1'b0;
                end else rv_c--;
            end else if (o_Mem_Req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    s_addr = o_Mem_Addr; s_wdata = o_Mem_Wdata; s_we = o_Mem_We;
                    wait_c = $urandom_range(ack_lo, ack_hi);
                    if (o_Mem_Addr >= B_BASE) begin
                        check("b_mem_while_requested", o_B_Requested, 1'b0);
                        check("b_mem_expected", exp_mem_b.size() > 0, 1'b1);
                        if (exp_mem_b.size() > 0) begin
                            e = exp_mem_b.pop_front();
                            check("b_mem_addr", o_Mem_Addr, e.addr);
                            check("b_mem_we", o_Mem_We, e.we);
                            if (e.we) check("b_mem_wdata", o_Mem_Wdata, e.data);
                        end
                    end else begin
                        check("a_mem_before_yield", yielded, 1'b1);
                        check("a_mem_expected", exp_mem_a.size() > 0, 1'b1);
                        if (exp_mem_a.size() > 0) begin
                            e = exp_mem_a.pop_front();
                            check("a_mem_addr", o_Mem_Addr, e.addr);
                            check("a_mem_we", o_Mem_We, e.we);
                            if (e.we) check("a_mem_wdata", o_Mem_Wdata, e.data);
                        end
                    end
                end else begin
                    check("mem_stable", {o_Mem_We, o_Mem_Addr, o_Mem_Wdata}, {s_we, s_addr, s_wdata});
                end
                if (wait_c == 0) begin
                    i_Mem_Ack = 1'b1;
                    in_req = 1'b0;
                    if (s_we) ctrl_mem[s_addr] = s_wdata;
                    else begin
                        rv_data = ctrl_mem.exists(s_addr) ? ctrl_mem[s_addr] : DATA_W'(s_addr);
                        dly = $urandom_range(rv_lo, rv_hi);
                        if (dly == 0) begin i_Mem_Rvalid = 1'b1; i_Mem_Rdata = rv_data; end
                        else begin rv_pend = 1'b1; rv_c = dly - 1; end
                    end
                end else wait_c--;
            end
        end
    end

    // Response monitor: every pulse is matched against the owning client's expected queue
    initial begin : mon
        op_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_A_Read_Valid || o_A_Write_Done) begin
                    pulses_a++;
                    check("a_pulse_expected", exp_pls_a.size() > 0, 1'b1);
                    check("a_pulse_b_requested", o_B_Requested, 1'b1);
                    if (exp_pls_a.size() > 0) begin
                        e = exp_pls_a.pop_front();
                        check("a_pulse_kind", {o_A_Read_Valid, o_A_Write_Done}, e.we ? 2'b01 : 2'b10);
                        if (!e.we) check("a_read_data", o_Read_Data, e.data);
                    end
                end
                if (o_B_Read_Valid || o_B_Write_Done) begin
                    pulses_b++;
                    check("b_pulse_expected", exp_pls_b.size() > 0, 1'b1);
                    check("b_pulse_b_requested", o_B_Requested, 1'b0);
                    if (exp_pls_b.size() > 0) begin
                        e = exp_pls_b.pop_front();
                        check("b_pulse_kind", {o_B_Read_Valid, o_B_Write_Done}, e.we ? 2'b01 : 2'b10);
                        if (!e.we) check("b_read_data", o_Read_Data, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin : main
        int pa, pb, t;
        logic exp_to;
`ifdef SDRAM_ARB_WATCHDOG_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_A_Read_Valid, o_A_Write_Done, o_B_Read_Valid, o_B_Write_Done, o_B_Requested,
                                o_Mem_Req, o_Mem_We, o_Yield_Timeout}, 8'h00);
        check("reset_buses", {o_Mem_Addr, o_Mem_Wdata, o_Read_Data}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Yield while nobody is asking is ignored
        b_active = 1'b1; i_B_Yield = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_yield_breq", o_B_Requested, 1'b0);
            check("stray_yield_req", o_Mem_Req, 1'b0);
        end
        i_B_Yield = 1'b0; b_active = 1'b0;

        // B read burst of 8 with Rdata = address
        pa = pulses_a; pb = pulses_b;
        b_burst(8, 0, B_BASE);
        repeat (4) @(negedge clk);
        check("ph_b_read_pulses", pulses_b - pb, 8);
        check("ph_b_read_no_a", pulses_a - pa, 0);

        // A write burst of 8 at 0 while B idle and yielding
        pa = pulses_a; pb = pulses_b;
        a_burst(8, 1, 22'h0);
        repeat (4) @(negedge clk);
        check("ph_a_write_pulses", pulses_a - pa, 8);
        check("ph_a_write_no_b", pulses_b - pb, 0);
        check("ph_a_released", o_B_Requested, 1'b0);

        // A interrupts a running B burst of 16, several controller timings
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin ack_lo = 0; ack_hi = 2; rv_lo = 0; rv_hi = 3; end
            if (r == 1) begin ack_lo = 1; ack_hi = 4; rv_lo = 1; rv_hi = 6; end
            if (r == 2) begin ack_lo = 0; ack_hi = 0; rv_lo = 0; rv_hi = 0; end
            pa = pulses_a; pb = pulses_b;
            fork
                b_burst(16, 2, B_BASE + 22'h40 + ADDR_W'(32 * r));
                begin
                    repeat ($urandom_range(6, 40)) @(negedge clk);
                    a_burst(8, 2, 22'h0);
                end
            join
            repeat (4) @(negedge clk);
            check("ph_mix_a_pulses", pulses_a - pa, 8);
            check("ph_mix_b_pulses", pulses_b - pb, 16);
        end

        // Ack held off 5 cycles with read data on the ack cycle
        ack_lo = 5; ack_hi = 5; rv_lo = 0; rv_hi = 0;
        pa = pulses_a; pb = pulses_b;
        fork
            b_burst(4, 2, B_BASE + 22'h100);
            begin repeat (3) @(negedge clk); a_burst(4, 2, 22'h4); end
        join
        repeat (4) @(negedge clk);
        check("ph_slow_ack_a_pulses", pulses_a - pa, 4);
        check("ph_slow_ack_b_pulses", pulses_b - pb, 4);

        // B never yields: watchdog behaviour, then B yields and A is served
        ack_lo = 0; ack_hi = 1; rv_lo = 0; rv_hi = 2;
        b_active = 1'b1; i_B_Yield = 1'b0;
        pa = pulses_a;
        fork a_burst(2, 1, 22'h200); join_none
        t = 0;
        while (!o_B_Requested && t < TMO) begin @(negedge clk); t++; end
        check("wd_b_requested", o_B_Requested, 1'b1);
        repeat (12) @(negedge clk);
        check("wd_before_limit", o_Yield_Timeout, 1'b0);
        check("wd_a_held_off", pulses_a - pa, 0);
        repeat (8) @(negedge clk);
        check("wd_after_limit", o_Yield_Timeout, exp_to);
        i_B_Yield = 1'b1;
        wait fork;
        i_B_Yield = 1'b0; b_active = 1'b0;
        t = 0;
        while (o_B_Requested && t < TMO) begin @(negedge clk); t++; end
        check("wd_a_served", pulses_a - pa, 2);
        check("wd_sticky", o_Yield_Timeout, exp_to);

        // Reset while a read waits for data: request dropped, no pulse afterwards
        ack_lo = 0; ack_hi = 0; rv_lo = 8; rv_hi = 8;
        b_active = 1'b1;
        begin
            op_t op;
            op.we = 1'b0; op.addr = B_BASE + 22'h300; op.data = '0;
            exp_mem_b.push_back(op);
        end
        @(negedge clk);
        i_B_Command = 2'd1; i_B_Address = B_BASE + 22'h300;
        t = 0;
        while (!o_Mem_Req && t < TMO) begin @(negedge clk); t++; end
        while (o_Mem_Req && t < TMO) begin @(negedge clk); t++; end
        check("rst_reached_read_wait", t < TMO, 1'b1);
        pb = pulses_b;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_addr", o_Mem_Addr, '0);
        check("rst_async_rdata", o_Read_Data, '0);
        check("rst_async_flags", {o_A_Read_Valid, o_A_Write_Done, o_B_Read_Valid, o_B_Write_Done, o_B_Requested,
                                  o_Mem_Req, o_Mem_We, o_Yield_Timeout}, 8'h00);
        i_B_Command = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_stray_pulse", pulses_b - pb, 0);
        check("rst_no_stray_req", o_Mem_Req, 1'b0);
        b_active = 1'b0;

        check("end_exp_pls_a", exp_pls_a.size(), 0);
        check("end_exp_pls_b", exp_pls_b.size(), 0);
        check("end_exp_mem_a", exp_mem_a.size(), 0);
        check("end_exp_mem_b", exp_mem_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
